// File: rtl/sram_responder_pkg.sv
// sram_responder_pkg
// Shared definitions for the SRAM responder: bus widths, the FSM state
// type and small helpers for saturating counters and byte-lane masks.
package sram_responder_pkg;

   localparam int SRAM_ADDR_W = 17;
   localparam int SRAM_DATA_W = 32;
   localparam int CNT_W       = 16;
   localparam int LANE_N      = SRAM_DATA_W / 8;
   localparam int PHASE_W     = 3;
   localparam int PULSE_W     = 8;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_DRIVE,
      RD_DONE,
      WRITE
   } state_e;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // UB_N covers the upper two bytes, LB_N the lower two.
   function automatic logic [LANE_N-1:0] lane_mask(input logic ub_n, input logic lb_n);
      return {~ub_n, ~ub_n, ~lb_n, ~lb_n};
   endfunction

   // Widen a byte mask to a per-bit mask.
   function automatic logic [SRAM_DATA_W-1:0] expand_mask(input logic [LANE_N-1:0] m);
      logic [SRAM_DATA_W-1:0] bits;
      bits = '0;
      for (int b = 0; b < LANE_N; b++) begin
         bits[b*8 +: 8] = {8{m[b]}};
      end
      return bits;
   endfunction

endpackage

// File: rtl/sram_responder_word_array.sv
// sram_word_array
// DEPTH x 32 word storage with a byte-write mask.
// Ports:
//   clk    - write clock
//   we     - write strobe, takes effect on the rising edge
//   waddr  - write word index
//   wdata  - write data
//   wmask  - per-byte write enable, bit b covers wdata[8b+7:8b]
//   raddr  - read word index
//   rdata  - combinational read data
module sram_word_array
   import sram_responder_pkg::*;
#(
   parameter int DEPTH = 131072,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [IDX_W-1:0]       waddr,
   input  logic [SRAM_DATA_W-1:0] wdata,
   input  logic [LANE_N-1:0]      wmask,
   input  logic [IDX_W-1:0]       raddr,
   output logic [SRAM_DATA_W-1:0] rdata
);

   logic [SRAM_DATA_W-1:0] mem [DEPTH];

   // Only the enabled byte lanes are overwritten; the others keep their
   // previous contents. The array is deliberately never reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < LANE_N; b++) begin
            if (wmask[b]) begin
               mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sram_responder.sv
// sram_responder
// Cycle-accurate stand-in for the board SRAM. Decodes the active-low
// strobes, stores masked writes into an internal array, returns read data
// on the shared DQ bus after READ_LAT edges for DRIVE_CYC cycles, and
// raises a sticky flag on write-protocol violations.
// Ports:
//   clk, rst_n            - clock and asynchronous active-low reset
//   SRAM_ADDR             - word address (index = address mod DEPTH)
//   SRAM_CE_N/OE_N/WE_N   - active-low chip, output and write enables
//   SRAM_UB_N/LB_N        - active-low lane enables, DQ[31:16] / DQ[15:0]
//   SRAM_DQ               - shared data bus, driven only in RD_DRIVE
//   proto_err             - sticky protocol-violation flag
//   wr_cnt, rd_cnt        - saturating committed-write / completed-read counts
module sram_responder
   import sram_responder_pkg::*;
#(
   parameter int READ_LAT   = 2,
   parameter int DRIVE_CYC  = 2,
   parameter int MIN_WE_CYC = 2,
   parameter int DEPTH      = 131072
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   input  logic                   SRAM_CE_N,
   input  logic                   SRAM_OE_N,
   input  logic                   SRAM_WE_N,
   input  logic                   SRAM_UB_N,
   input  logic                   SRAM_LB_N,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic                   proto_err,
   output logic [CNT_W-1:0]       wr_cnt,
   output logic [CNT_W-1:0]       rd_cnt
);

   localparam int IDX_W = $clog2(DEPTH);

   state_e                 state_q, state_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [PHASE_W-1:0]     lat_cnt_q, lat_cnt_d;
   logic [PHASE_W-1:0]     drive_cnt_q, drive_cnt_d;
   logic [PULSE_W-1:0]     pulse_cnt_q, pulse_cnt_d;
   logic [IDX_W-1:0]       wr_addr_q, wr_addr_d;
   logic [SRAM_DATA_W-1:0] wr_data_q, wr_data_d;
   logic [LANE_N-1:0]      wr_mask_q, wr_mask_d;
   logic [SRAM_DATA_W-1:0] rd_data_q, rd_data_d;
   logic                   proto_err_q, proto_err_d;
   logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;

   logic                   addr_change;
   logic [LANE_N-1:0]      cur_mask;
   logic [SRAM_DATA_W-1:0] cur_bits;
   logic                   start_read;
   logic                   start_write;
   logic                   mem_we;
   logic [SRAM_DATA_W-1:0] mem_rdata;
   logic                   drive_en;

   sram_word_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_addr_q),
      .wdata (wr_data_q),
      .wmask (wr_mask_q),
      .raddr (SRAM_ADDR[IDX_W-1:0]),
      .rdata (mem_rdata)
   );

   // Next-state logic. Read states share one exit priority: CE_N high
   // ends the access, WE_N low turns it into a write (WE_N beats OE_N),
   // OE_N high ends it, and a new address restarts the latency window.
   // Entering WRITE already counts as the first WE_N-low edge, so a
   // two-cycle pulse reaches pulse_cnt=2 by the commit edge.
   always_comb begin
      state_d     = state_q;
      addr_d      = SRAM_ADDR;
      lat_cnt_d   = lat_cnt_q;
      drive_cnt_d = drive_cnt_q;
      pulse_cnt_d = pulse_cnt_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_mask_d   = wr_mask_q;
      rd_data_d   = rd_data_q;
      proto_err_d = proto_err_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      mem_we      = 1'b0;
      start_read  = 1'b0;
      start_write = 1'b0;

      addr_change = (SRAM_ADDR != addr_q);
      cur_mask    = lane_mask(SRAM_UB_N, SRAM_LB_N);
      cur_bits    = expand_mask(cur_mask);

      case (state_q)
         IDLE: begin
            if (!SRAM_CE_N) begin
               if (!SRAM_WE_N) begin
                  start_write = 1'b1;
               end else if (!SRAM_OE_N) begin
                  start_read = 1'b1;
               end
            end
         end

         RD_WAIT: begin
            if (SRAM_CE_N) begin
               state_d = IDLE;
            end else if (!SRAM_WE_N) begin
               start_write = 1'b1;
            end else if (SRAM_OE_N) begin
               state_d = IDLE;
            end else if (addr_change) begin
               start_read = 1'b1;
            end else if (lat_cnt_q == PHASE_W'(READ_LAT - 1)) begin
               rd_data_d   = mem_rdata & cur_bits;
               drive_cnt_d = PHASE_W'(1);
               state_d     = RD_DRIVE;
            end else begin
               lat_cnt_d = lat_cnt_q + PHASE_W'(1);
            end
         end

         RD_DRIVE: begin
            if (SRAM_CE_N) begin
               state_d = IDLE;
            end else if (!SRAM_WE_N) begin
               start_write = 1'b1;
            end else if (SRAM_OE_N) begin
               state_d = IDLE;
            end else if (addr_change) begin
               start_read = 1'b1;
            end else if (drive_cnt_q == PHASE_W'(DRIVE_CYC)) begin
               rd_cnt_d = sat_inc(rd_cnt_q);
               state_d  = RD_DONE;
            end else begin
               drive_cnt_d = drive_cnt_q + PHASE_W'(1);
            end
         end

         RD_DONE: begin
            if (SRAM_CE_N) begin
               state_d = IDLE;
            end else if (!SRAM_WE_N) begin
               start_write = 1'b1;
            end else if (SRAM_OE_N) begin
               state_d = IDLE;
            end else if (addr_change) begin
               start_read = 1'b1;
            end
         end

         WRITE: begin
            if (!SRAM_WE_N) begin
               if (SRAM_CE_N) begin
                  proto_err_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  wr_addr_d   = SRAM_ADDR[IDX_W-1:0];
                  wr_data_d   = SRAM_DQ;
                  wr_mask_d   = cur_mask;
                  pulse_cnt_d = (pulse_cnt_q == '1) ? pulse_cnt_q : pulse_cnt_q + PULSE_W'(1);
                  if (addr_change) begin
                     proto_err_d = 1'b1;
                  end
               end
            end else begin
               mem_we   = 1'b1;
               wr_cnt_d = sat_inc(wr_cnt_q);
               if (pulse_cnt_q < PULSE_W'(MIN_WE_CYC)) begin
                  proto_err_d = 1'b1;
               end
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Entering WRITE captures the bus on this very edge.
      if (start_write) begin
         wr_addr_d   = SRAM_ADDR[IDX_W-1:0];
         wr_data_d   = SRAM_DQ;
         wr_mask_d   = cur_mask;
         pulse_cnt_d = PULSE_W'(1);
         state_d     = WRITE;
      end

      // A read whose address is first seen on this edge. With a latency of
      // one the data must already be on the bus after this edge, so the
      // wait state is skipped and the array is sampled immediately.
      if (start_read) begin
         if (READ_LAT == 1) begin
            rd_data_d   = mem_rdata & cur_bits;
            drive_cnt_d = PHASE_W'(1);
            state_d     = RD_DRIVE;
         end else begin
            lat_cnt_d = PHASE_W'(1);
            state_d   = RD_WAIT;
         end
      end
   end

   // State and datapath registers; the array itself has no reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         lat_cnt_q   <= '0;
         drive_cnt_q <= '0;
         pulse_cnt_q <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_mask_q   <= '0;
         rd_data_q   <= '0;
         proto_err_q <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         lat_cnt_q   <= lat_cnt_d;
         drive_cnt_q <= drive_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_mask_q   <= wr_mask_d;
         rd_data_q   <= rd_data_d;
         proto_err_q <= proto_err_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
      end
   end

   // The bus is released combinationally as soon as WE_N falls so a write
   // arriving during RD_DRIVE never fights the controller's data.
   assign drive_en = (state_q == RD_DRIVE) && SRAM_WE_N;
   assign SRAM_DQ  = drive_en ? (rd_data_q & cur_bits) : {SRAM_DATA_W{1'bz}};

   assign proto_err = proto_err_q;
   assign wr_cnt    = wr_cnt_q;
   assign rd_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder
// Drives three responder instances (default timing, READ_LAT=1/DRIVE_CYC=1,
// READ_LAT=3/DRIVE_CYC=2) with controller-style accesses and compares
// against a reference word array kept as an associative array.
module tb_sram_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [16:0] sram_addr = '0;
   logic [2:0]  ce_n = '1;
   logic        oe_n = 1'b1;
   logic        we_n = 1'b1;
   logic        ub_n = 1'b0;
   logic        lb_n = 1'b0;
   logic        tb_drive = 1'b0;
   logic [31:0] tb_dq = '0;

   wire  [31:0] dq0, dq1, dq2;
   logic        proto [3];
   logic [15:0] wrc [3];
   logic [15:0] rdc [3];

   int checks = 0;
   int errors = 0;
   int lat_of [3]   = '{2, 1, 3};
   int drv_of [3]   = '{2, 1, 2};
   int depth_of [3] = '{131072, 1024, 1024};
   int wr_exp [3]   = '{0, 0, 0};
   int rd_exp [3]   = '{0, 0, 0};
   logic [31:0] ref_mem [int];

   assign dq0 = tb_drive ? tb_dq : {32{1'bz}};
   assign dq1 = tb_drive ? tb_dq : {32{1'bz}};
   assign dq2 = tb_drive ? tb_dq : {32{1'bz}};

   wire z0 = (dq0 === {32{1'bz}});
   wire z1 = (dq1 === {32{1'bz}});
   wire z2 = (dq2 === {32{1'bz}});

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   sram_responder dut0 (
      .clk(clk), .rst_n(rst_n), .SRAM_ADDR(sram_addr),
      .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_DQ(dq0),
      .proto_err(proto[0]), .wr_cnt(wrc[0]), .rd_cnt(rdc[0])
   );

   sram_responder #(.READ_LAT(1), .DRIVE_CYC(1), .MIN_WE_CYC(2), .DEPTH(1024)) dut1 (
      .clk(clk), .rst_n(rst_n), .SRAM_ADDR(sram_addr),
      .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_DQ(dq1),
      .proto_err(proto[1]), .wr_cnt(wrc[1]), .rd_cnt(rdc[1])
   );

   sram_responder #(.READ_LAT(3), .DRIVE_CYC(2), .MIN_WE_CYC(2), .DEPTH(1024)) dut2 (
      .clk(clk), .rst_n(rst_n), .SRAM_ADDR(sram_addr),
      .SRAM_CE_N(ce_n[2]), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_DQ(dq2),
      .proto_err(proto[2]), .wr_cnt(wrc[2]), .rd_cnt(rdc[2])
   );

   // Hard stop in case the sequence ever stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_dq(input int w);
      case (w)
         0:       return dq0;
         1:       return dq1;
         default: return dq2;
      endcase
   endfunction

   function automatic logic [31:0] get_z(input int w);
      case (w)
         0:       return {31'b0, z0};
         1:       return {31'b0, z1};
         default: return {31'b0, z2};
      endcase
   endfunction

   // Reference model: one word per (instance, address mod DEPTH).
   function automatic int mem_key(input int w, input logic [16:0] a);
      return w * (1 << 20) + (int'(a) % depth_of[w]);
   endfunction

   function automatic logic [31:0] lane_bits(input logic ub, input logic lb);
      return {ub ? 16'h0000 : 16'hFFFF, lb ? 16'h0000 : 16'hFFFF};
   endfunction

   function automatic logic [31:0] model_read(input int w, input logic [16:0] a);
      int k = mem_key(w, a);
      return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
   endfunction

   task automatic model_write(input int w, input logic [16:0] a, input logic [31:0] d,
                              input logic ub, input logic lb);
      logic [31:0] m = lane_bits(ub, lb);
      ref_mem[mem_key(w, a)] = (model_read(w, a) & ~m) | (d & m);
   endtask

   // Shared reset of all instances; the model array survives.
   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      ce_n  = '1;
      oe_n  = 1'b1;
      we_n  = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_exp[i] = 0;
         rd_exp[i] = 0;
      end
   endtask

   // Controller-style write: WE_N low for 'pulse' edges, then one edge with
   // WE_N high commits, then CE_N is released.
   task automatic applyWrite(input int w, input logic [16:0] a, input logic [31:0] d,
                             input logic ub, input logic lb, input int pulse);
      @(negedge clk);
      sram_addr = a;
      ce_n[w]   = 1'b0;
      oe_n      = 1'b1;
      we_n      = 1'b0;
      ub_n      = ub;
      lb_n      = lb;
      tb_dq     = d;
      tb_drive  = 1'b1;
      repeat (pulse) @(negedge clk);
      we_n = 1'b1;
      @(negedge clk);
      ce_n     = '1;
      tb_drive = 1'b0;
      model_write(w, a, d, ub, lb);
      wr_exp[w]++;
   endtask

   // Controller-style read. After the j-th edge following the address edge
   // the bus must carry data for READ_LAT-1 <= j < READ_LAT-1+DRIVE_CYC and
   // be high-Z otherwise.
   task automatic applyRead(input int w, input logic [16:0] a, input logic ub, input logic lb);
      int          lat = lat_of[w];
      int          drv = drv_of[w];
      logic [31:0] exp = model_read(w, a) & lane_bits(ub, lb);
      @(negedge clk);
      sram_addr = a;
      ce_n[w]   = 1'b0;
      oe_n      = 1'b0;
      we_n      = 1'b1;
      ub_n      = ub;
      lb_n      = lb;
      tb_drive  = 1'b0;
      for (int j = 0; j < lat + drv; j++) begin
         @(negedge clk);
         if (j >= lat - 1 && j < lat - 1 + drv) begin
            checkOutput($sformatf("rd%0d_data_a%05h_c%0d", w, a, j), get_dq(w), exp);
            checkOutput($sformatf("rd%0d_driven_a%05h_c%0d", w, a, j), get_z(w), 32'd0);
         end else begin
            checkOutput($sformatf("rd%0d_hiz_a%05h_c%0d", w, a, j), get_z(w), 32'd1);
         end
      end
      ce_n = '1;
      oe_n = 1'b1;
      rd_exp[w]++;
   endtask

   task automatic checkCounters(input string tag, input int w);
      checkOutput({tag, "_wr_cnt"}, 32'(wrc[w]), 32'(wr_exp[w]));
      checkOutput({tag, "_rd_cnt"}, 32'(rdc[w]), 32'(rd_exp[w]));
   endtask

   initial begin
      logic [16:0] pool [8];
      int          idx;

      $display("[TB] start");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset state
      checkOutput("reset_hiz0", get_z(0), 32'd1);
      checkOutput("reset_hiz1", get_z(1), 32'd1);
      checkOutput("reset_hiz2", get_z(2), 32'd1);
      checkOutput("reset_proto", 32'(proto[0]), 32'd0);
      checkCounters("reset", 0);

      // Write then read
      applyWrite(0, 17'h00010, 32'hDEADBEEF, 1'b0, 1'b0, 2);
      checkCounters("after_write", 0);
      checkOutput("after_write_proto", 32'(proto[0]), 32'd0);
      applyRead(0, 17'h00010, 1'b0, 1'b0);
      checkCounters("after_read", 0);

      // Lane masking
      applyWrite(0, 17'h00010, 32'h12345678, 1'b1, 1'b0, 2);
      applyRead(0, 17'h00010, 1'b0, 1'b0);
      applyRead(0, 17'h00010, 1'b0, 1'b1);
      checkOutput("lane_model", model_read(0, 17'h00010), 32'hDEAD5678);
      checkOutput("lane_proto", 32'(proto[0]), 32'd0);

      // Reset in the middle of a drive window
      @(negedge clk);
      sram_addr = 17'h00010;
      ce_n[0]   = 1'b0;
      oe_n      = 1'b0;
      we_n      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre_reset_driven", get_z(0), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_hiz", get_z(0), 32'd1);
      checkOutput("mid_reset_proto", 32'(proto[0]), 32'd0);
      checkOutput("mid_reset_wr_cnt", 32'(wrc[0]), 32'd0);
      checkOutput("mid_reset_rd_cnt", 32'(rdc[0]), 32'd0);
      @(negedge clk);
      ce_n  = '1;
      oe_n  = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_exp[i] = 0;
         rd_exp[i] = 0;
      end

      // Minimum latency: index wraps modulo DEPTH=1024
      applyWrite(1, 17'h01403, 32'hA5A55A5A, 1'b0, 1'b0, 2);
      applyRead(1, 17'h00003, 1'b0, 1'b0);
      checkCounters("lat1", 1);

      // Address change during RD_WAIT restarts the latency count
      applyWrite(2, 17'h00020, 32'h0BADF00D, 1'b0, 1'b0, 2);
      applyWrite(2, 17'h00021, 32'hFEEDC0DE, 1'b0, 1'b0, 2);
      @(negedge clk);
      sram_addr = 17'h00020;
      ce_n[2]   = 1'b0;
      oe_n      = 1'b0;
      we_n      = 1'b1;
      applyRead(2, 17'h00021, 1'b0, 1'b0);
      checkCounters("lat3_restart", 2);

      // One-cycle WE_N pulse still commits but flags the error
      applyReset();
      applyWrite(0, 17'h00040, 32'hCAFEF00D, 1'b0, 1'b0, 1);
      checkOutput("short_pulse_proto", 32'(proto[0]), 32'd1);
      applyRead(0, 17'h00040, 1'b0, 1'b0);
      checkCounters("short_pulse", 0);

      // Address change while WE_N is low
      applyReset();
      checkOutput("post_reset_proto", 32'(proto[0]), 32'd0);
      @(negedge clk);
      sram_addr = 17'h00050;
      ce_n[0]   = 1'b0;
      oe_n      = 1'b1;
      we_n      = 1'b0;
      ub_n      = 1'b0;
      lb_n      = 1'b0;
      tb_dq     = 32'hA1B2C3D4;
      tb_drive  = 1'b1;
      @(negedge clk);
      sram_addr = 17'h00051;
      @(negedge clk);
      we_n = 1'b1;
      @(negedge clk);
      ce_n     = '1;
      tb_drive = 1'b0;
      wr_exp[0]++;
      checkOutput("addr_change_proto", 32'(proto[0]), 32'd1);
      checkCounters("addr_change", 0);

      // CE_N rising while WE_N is low aborts the write
      applyReset();
      applyWrite(0, 17'h00060, 32'h11112222, 1'b0, 1'b0, 2);
      checkOutput("pre_abort_proto", 32'(proto[0]), 32'd0);
      @(negedge clk);
      sram_addr = 17'h00060;
      ce_n[0]   = 1'b0;
      we_n      = 1'b0;
      tb_dq     = 32'h99998888;
      tb_drive  = 1'b1;
      @(negedge clk);
      ce_n = '1;
      @(negedge clk);
      we_n     = 1'b1;
      tb_drive = 1'b0;
      checkOutput("abort_proto", 32'(proto[0]), 32'd1);
      applyRead(0, 17'h00060, 1'b0, 1'b0);
      checkCounters("abort", 0);

      // Randomised controller traffic against the reference array
      applyReset();
      for (int i = 0; i < 8; i++) begin
         pool[i] = 17'($urandom);
         applyWrite(0, pool[i], $urandom, 1'b0, 1'b0, 2);
      end
      for (int n = 0; n < 100; n++) begin
         idx = $urandom_range(7);
         if ($urandom_range(1) == 1) begin
            applyWrite(0, pool[idx], $urandom, 1'($urandom_range(1)),
                       1'($urandom_range(1)), $urandom_range(3, 2));
         end else begin
            applyRead(0, pool[idx], 1'($urandom_range(1)), 1'($urandom_range(1)));
         end
      end
      @(negedge clk);
      checkCounters("random", 0);
      checkOutput("random_proto", 32'(proto[0]), 32'd0);
      checkOutput("random_hiz", get_z(0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
